pico_mavg_stream_engine: RTL

// - Streaming moving-average engine for the DDR3 moving-average datapath; sits between the DDR read stream and the DDR write stream.
// - Splits each input word into LANES independent lanes and outputs one windowed average word per input word.
// - Window size (power of two) and frame length are set per frame through a start command. This replaces the fixed 4-tap, single-lane filter.

---
 rtl/pico_mavg_stream_engine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pico_mavg_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pico_mavg_stream_engine                                    |
// | Description : Streaming multi-lane moving-average engine. Each input     |
// |               word is split into LANES lanes. Every accepted word makes  |
// |               one output word. Each output lane is the sum of the last   |
// |               2^k samples of that lane, shifted right by k.              |
// |               The window (k) and frame length are latched by start.      |
// | Option      : PICO_MAVG_ROUND_EN - when defined, the output rounds half  |
// |               up (adds 2^(k-1) before the shift) instead of truncating.  |
// | Ports       : clk, rst_n          clock / async active-low reset         |
// |               start_i, cfg_*_i    frame command (sampled in IDLE only)   |
// |               busy_o, done_o      frame status, done is a 1-cycle pulse  |
// |               s_valid_i/s_ready_o/s_data_i       input stream            |
// |               m_valid_o/m_ready_i/m_data_o/m_last_o  output stream       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pico_mavg_stream_engine #(
    parameter int LANES        = 4,
    parameter int LANE_W       = 32,
    parameter int MAX_WIN_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [2:0]              cfg_win_log2_i,
    input  logic [31:0]             cfg_len_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [LANES*LANE_W-1:0] s_data_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [LANES*LANE_W-1:0] m_data_o,
    output logic                    m_last_o
);

    localparam int W      = LANES * LANE_W;
    localparam int DEPTH  = 1 << MAX_WIN_LOG2;
    localparam int PTR_W  = MAX_WIN_LOG2;
    localparam int FILL_W = MAX_WIN_LOG2 + 1;
    localparam int SUM_W  = LANE_W + MAX_WIN_LOG2;
    localparam int SUMX_W = SUM_W + 1;
    localparam logic [2:0] K_MAX = 3'(MAX_WIN_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        k_q;
    logic [31:0]       remaining_q;
    logic [FILL_W-1:0] fill_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              done_q;
    logic              m_valid_q;
    logic              m_last_q;
    logic [W-1:0]      m_data_q;
    logic [W-1:0]      m_data_d;

    // History is deliberately not reset: fill_q decides which entries are live.
    logic [W-1:0]      hist_q [DEPTH];

    logic [FILL_W-1:0] win;
    logic [PTR_W-1:0]  old_ptr;
    logic              use_old;
    logic [W-1:0]      old_word;
    logic              s_accept;
    logic              m_accept;
    logic              start_ok;
    logic [2:0]        k_cfg;

    assign win      = FILL_W'(1) << k_q;
    // For k == MAX_WIN_LOG2 the low bits of win are zero, so the sample
    // leaving the window is the one about to be overwritten at ptr_q.
    assign old_ptr  = ptr_q - win[PTR_W-1:0];
    assign use_old  = (fill_q >= win);
    assign old_word = use_old ? hist_q[old_ptr] : '0;

    assign s_ready_o = (state_q == ST_RUN) && (remaining_q != '0) &&
                       (!m_valid_q || m_ready_i);
    assign s_accept  = s_valid_i && s_ready_o;
    assign m_accept  = m_valid_q && m_ready_i;
    assign start_ok  = (state_q == ST_IDLE) && start_i;
    assign k_cfg     = (cfg_win_log2_i > K_MAX) ? K_MAX : cfg_win_log2_i;

`ifdef PICO_MAVG_ROUND_EN
    logic [SUMX_W-1:0] round_add;
    assign round_add = (k_q == 3'd0) ? '0 : (SUMX_W'(1) << (k_q - 3'd1));
`endif

    // Per-lane running sums and output arithmetic
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] lane_x;
        logic [LANE_W-1:0] lane_old;
        logic [SUM_W-1:0]  sum_q;
        logic [SUM_W-1:0]  sum_d;
        logic [SUMX_W-1:0] biased;

        assign lane_x   = s_data_i[l*LANE_W +: LANE_W];
        assign lane_old = old_word[l*LANE_W +: LANE_W];
        // The window holds at most 2^MAX_WIN_LOG2 samples, so SUM_W bits
        // can never overflow and the subtraction never underflows.
        assign sum_d    = sum_q + SUM_W'(lane_x) - SUM_W'(lane_old);
`ifdef PICO_MAVG_ROUND_EN
        assign biased   = {1'b0, sum_d} + round_add;
`else
        assign biased   = {1'b0, sum_d};
`endif
        assign m_data_d[l*LANE_W +: LANE_W] = LANE_W'(biased >> k_q);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
            end else if (start_ok) begin
                sum_q <= '0;
            end else if (s_accept) begin
                sum_q <= sum_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_accept) begin
            hist_q[ptr_q] <= s_data_i;
        end
    end

    // Control FSM with registered stream and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            remaining_q <= '0;
            fill_q      <= '0;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            done_q <= 1'b0;

            if (m_accept) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end

            // s_ready already requires the output slot to be free or draining.
            if (s_accept) begin
                m_valid_q   <= 1'b1;
                m_data_q    <= m_data_d;
                m_last_q    <= (remaining_q == 32'd1);
                remaining_q <= remaining_q - 32'd1;
                ptr_q       <= ptr_q + PTR_W'(1);
                if (fill_q < win) begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        k_q         <= k_cfg;
                        remaining_q <= cfg_len_i;
                        fill_q      <= '0;
                        ptr_q       <= '0;
                        state_q     <= (cfg_len_i == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (m_accept && m_last_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;

endmodule
`default_nettype wire
